// File: rtl/decoder_scan_seq_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding and
// default widths of the select code and the dwell count.
package decoder_scan_seq_pkg;

  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned DW_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter timing how long each select code stays enabled.
// expire_c is high whenever the count has reached zero.
module scan_dwell_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  // Clear beats load beats decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire_c = (cnt == '0);

endmodule

// File: rtl/decoder_scan_seq.sv
// Scan sequencer for a 4-to-16 decoder: steps the select code 0..last,
// holding each code enabled for a dwell period with a one-cycle blank between.
module decoder_scan_seq
  import decoder_scan_seq_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned DW_W  = DW_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic [DW_W-1:0]  dwell_in,
  input  logic [SEL_W-1:0] last_in,
  output logic [SEL_W-1:0] sel_out,
  output logic             en_out,
  output logic             busy_out,
  output logic             wrap_out
);

  scan_state_e      state;
  logic [DW_W-1:0]  dwell_r;
  logic [SEL_W-1:0] last_r;

  logic             cnt_clr_c;
  logic             cnt_load_c;
  logic             cnt_dec_c;
  logic [DW_W-1:0]  cnt_load_val_c;
  logic             cnt_expire_c;

  // A dwell of zero behaves as one; the counter holds "cycles remaining - 1".
  function automatic logic [DW_W-1:0] dwell_m1(input logic [DW_W-1:0] d);
    return (d == '0) ? '0 : d - DW_W'(1);
  endfunction

  // Counter control follows the state transitions taken on the same edge.
  always_comb begin
    cnt_clr_c      = 1'b0;
    cnt_load_c     = 1'b0;
    cnt_dec_c      = 1'b0;
    cnt_load_val_c = dwell_m1(dwell_r);
    case (state)
      ST_IDLE: begin
        cnt_load_val_c = dwell_m1(dwell_in);
        cnt_load_c     = start_in && !stop_in;
      end
      ST_SCAN: begin
        cnt_clr_c = stop_in;
        cnt_dec_c = !stop_in && !cnt_expire_c;
      end
      ST_BLANK: begin
        cnt_clr_c  = stop_in;
        cnt_load_c = !stop_in;
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  scan_dwell_cnt #(
    .W(DW_W)
  ) u_dwell_cnt (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .clr      (cnt_clr_c),
    .load     (cnt_load_c),
    .load_val (cnt_load_val_c),
    .dec      (cnt_dec_c),
    .expire_c (cnt_expire_c)
  );

  // State and all outputs are registered; sel_out only moves while en_out is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_IDLE;
      dwell_r  <= '0;
      last_r   <= '0;
      sel_out  <= '0;
      en_out   <= 1'b0;
      busy_out <= 1'b0;
      wrap_out <= 1'b0;
    end else begin
      wrap_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in && !stop_in) begin
            state    <= ST_SCAN;
            dwell_r  <= dwell_in;
            last_r   <= last_in;
            sel_out  <= '0;
            en_out   <= 1'b1;
            busy_out <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (stop_in) begin
            state    <= ST_IDLE;
            sel_out  <= '0;
            en_out   <= 1'b0;
            busy_out <= 1'b0;
          end else if (cnt_expire_c) begin
            state  <= ST_BLANK;
            en_out <= 1'b0;
          end
        end
        ST_BLANK: begin
          if (stop_in) begin
            state    <= ST_IDLE;
            sel_out  <= '0;
            en_out   <= 1'b0;
            busy_out <= 1'b0;
          end else begin
            state  <= ST_SCAN;
            en_out <= 1'b1;
            if (sel_out == last_r) begin
              sel_out  <= '0;
              wrap_out <= 1'b1;
            end else begin
              sel_out <= sel_out + SEL_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          sel_out  <= '0;
          en_out   <= 1'b0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: a cycle-count model of the scan schedule plus
// an active-low 4-to-16 decoder model, with directed scenarios and literal checks.
module tb_decoder_scan_seq;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       start_in;
  logic       stop_in;
  logic [7:0] dwell_in;
  logic [3:0] last_in;
  logic [3:0] sel_out;
  logic       en_out;
  logic       busy_out;
  logic       wrap_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  decoder_scan_seq #(.SEL_W(4), .DW_W(8)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start_in (start_in),
    .stop_in  (stop_in),
    .dwell_in (dwell_in),
    .last_in  (last_in),
    .sel_out  (sel_out),
    .en_out   (en_out),
    .busy_out (busy_out),
    .wrap_out (wrap_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: t counts edges since start; each code occupies d+1 cycles (d enabled, 1 blank).
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_d      = 1;
  int m_last   = 0;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (stop_in) m_active <= 1'b0;
      else         m_t <= m_t + 1;
    end else if (start_in && !stop_in) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_d      <= (dwell_in == 8'd0) ? 1 : int'(dwell_in);
      m_last   <= int'(last_in);
    end
  end

  function automatic int exp_sel();
    return m_active ? (m_t / (m_d + 1)) % (m_last + 1) : 0;
  endfunction
  function automatic int exp_en();
    return (m_active && ((m_t % (m_d + 1)) < m_d)) ? 1 : 0;
  endfunction
  function automatic int exp_wrap();
    return (m_active && m_t > 0 && (m_t % (m_d + 1)) == 0 && exp_sel() == 0) ? 1 : 0;
  endfunction
  function automatic logic [15:0] dec_al(input logic en, input logic [3:0] sel);
    logic [15:0] one;
    one = 16'd1;
    return en ? ~(one << sel) : 16'hFFFF;
  endfunction

  // Per-cycle comparison against the model, including the decoder's y pattern.
  always @(negedge clk_in) begin
    if (chk_on) begin
      chk("sel", 32'(sel_out), 32'(exp_sel()));
      chk("en", 32'(en_out), 32'(exp_en()));
      chk("busy", 32'(busy_out), 32'(m_active));
      chk("wrap", 32'(wrap_out), 32'(exp_wrap()));
      chk("dec_y", 32'(dec_al(en_out, sel_out)),
          32'(dec_al(exp_en() != 0, 4'(exp_sel()))));
    end
  end

  task automatic start_scan(input logic [7:0] d, input logic [3:0] l);
    dwell_in = d;
    last_in  = l;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic go_idle();
    stop_in = 1'b1;
    @(negedge clk_in);
    stop_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    int w;
    logic [3:0] zd_en;
    logic [7:0] zd_sel;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    stop_in  = 1'b0;
    dwell_in = 8'd0;
    last_in  = 4'd0;
    #12;
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_en", 32'(en_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_wrap", 32'(wrap_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    chk_on   = 1'b1;
    repeat (2) @(negedge clk_in);

    // Basic scan: dwell 3, last 3 -> 16-cycle loop
    start_scan(8'd3, 4'd3);
    w = 0;
    for (int k = 0; k <= 32; k++) begin
      if (wrap_out) w++;
      if (k == 0)  begin chk("basic_k0_sel", 32'(sel_out), 32'd0); chk("basic_k0_en", 32'(en_out), 32'd1); end
      if (k == 3)  chk("basic_k3_en", 32'(en_out), 32'd0);
      if (k == 4)  chk("basic_k4_sel", 32'(sel_out), 32'd1);
      if (k == 12) chk("basic_k12_sel", 32'(sel_out), 32'd3);
      if (k == 16) begin chk("basic_k16_sel", 32'(sel_out), 32'd0); chk("basic_k16_wrap", 32'(wrap_out), 32'd1); end
      @(negedge clk_in);
    end
    chk("basic_wraps", 32'(w), 32'd2);
    go_idle();

    // Stop during the blank after code 3 suppresses the wrap
    start_scan(8'd3, 4'd3);
    repeat (15) @(negedge clk_in);
    chk("stop_pre_sel", 32'(sel_out), 32'd3);
    chk("stop_pre_en", 32'(en_out), 32'd0);
    stop_in = 1'b1;
    @(negedge clk_in);
    stop_in = 1'b0;
    chk("stop_sel", 32'(sel_out), 32'd0);
    chk("stop_en", 32'(en_out), 32'd0);
    chk("stop_busy", 32'(busy_out), 32'd0);
    chk("stop_wrap", 32'(wrap_out), 32'd0);
    repeat (2) @(negedge clk_in);

    // Zero dwell behaves as one: en 1,0,1,0 and sel 0,0,1,1
    zd_en  = 4'b0101;
    zd_sel = 8'b0101_0000;
    start_scan(8'd0, 4'd1);
    for (int k = 0; k < 4; k++) begin
      chk("zero_en", 32'(en_out), 32'(zd_en[k]));
      chk("zero_sel", 32'(sel_out), 32'(zd_sel[2*k +: 2]));
      @(negedge clk_in);
    end
    chk("zero_wrap", 32'(wrap_out), 32'd1);
    go_idle();

    // Full range 0..15 with dwell 1 -> wrap every 32 cycles
    start_scan(8'd1, 4'd15);
    w = 0;
    for (int k = 0; k <= 64; k++) begin
      if (wrap_out) w++;
      if (k == 30) begin chk("full_k30_sel", 32'(sel_out), 32'd15); chk("full_k30_en", 32'(en_out), 32'd1); end
      if (k == 32) begin chk("full_k32_sel", 32'(sel_out), 32'd0); chk("full_k32_wrap", 32'(wrap_out), 32'd1); end
      @(negedge clk_in);
    end
    chk("full_wraps", 32'(w), 32'd2);
    go_idle();

    // Start and stop together in IDLE: stop wins
    start_in = 1'b1;
    stop_in  = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    stop_in  = 1'b0;
    chk("both_busy", 32'(busy_out), 32'd0);
    @(negedge clk_in);
    chk("both_busy2", 32'(busy_out), 32'd0);

    // Mid-scan changes to last/dwell and a repeated start are ignored
    start_scan(8'd1, 4'd3);
    last_in  = 4'd7;
    dwell_in = 8'd5;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (7) @(negedge clk_in);
    chk("ign_k8_sel", 32'(sel_out), 32'd0);
    chk("ign_k8_wrap", 32'(wrap_out), 32'd1);
    go_idle();
    start_scan(8'd1, 4'd7);
    repeat (8) @(negedge clk_in);
    chk("new_k8_sel", 32'(sel_out), 32'd4);
    go_idle();

    // Asynchronous reset at sel 5, no clock edge before the check
    start_scan(8'd3, 4'd7);
    repeat (21) @(negedge clk_in);
    chk("pre_rst_sel", 32'(sel_out), 32'd5);
    chk("pre_rst_en", 32'(en_out), 32'd1);
    #1 rst_n_in = 1'b0;
    #1;
    chk("async_sel", 32'(sel_out), 32'd0);
    chk("async_en", 32'(en_out), 32'd0);
    chk("async_busy", 32'(busy_out), 32'd0);
    chk("async_wrap", 32'(wrap_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("post_rst_busy", 32'(busy_out), 32'd0);
    chk("post_rst_en", 32'(en_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 Parameter SEL_W, default 4: width of the select code driven to the downstream 4-to-16 decoder.
REQ-002 Parameter DW_W, default 8: width of the dwell-count input.
REQ-003 clk_in  input  1: single clock; all state changes on the rising edge.
REQ-004 rst_n_in  input  1: reset, asynchronous and active-low.
REQ-005 start_in  input  1: one-cycle request to begin scanning; sampled only in IDLE.
REQ-006 stop_in  input  1: request to abort scanning; sampled in any state.
REQ-007 dwell_in  input  DW_W: cycles each select code is held enabled; captured at start.
REQ-008 last_in  input  SEL_W: highest select code in the scan range; captured at start.
REQ-009 sel_out  output  SEL_W: registered select code, connects to decoder sel_in.
REQ-010 en_out  output  1: registered active-high enable, connects to decoder en_in.
REQ-011 busy_out  output  1: high in every state except IDLE.
REQ-012 wrap_out  output  1: one-cycle pulse on the clock edge where sel_out returns from the captured last value to 0.

Function
REQ-013 FSM states: IDLE, SCAN, BLANK; encoded as a 2-bit registered state.
REQ-014 IDLE -> SCAN on start_in=1 and stop_in=0: capture dwell_in into dwell_r and last_in into last_r; sel_out=0; en_out=1; load the dwell counter.
REQ-015 Effective dwell = dwell_r, but dwell_r=0 is treated as 1; en_out stays high for exactly the effective dwell cycles per code.
REQ-016 SCAN -> BLANK when the dwell counter expires; en_out=0 for exactly one cycle in BLANK (break-before-make, decoder outputs all inactive).
REQ-017 BLANK -> SCAN: sel_out increments by 1; if sel_out == last_r, sel_out becomes 0 and wrap_out pulses for that cycle only.
REQ-018 sel_out changes only on the BLANK -> SCAN transition or on entry to IDLE; never while en_out=1.
REQ-019 last_r = all-ones (15 at SEL_W=4): full range, wraps 15 -> 0 with no overflow beyond SEL_W bits.
REQ-020 last_r = 0: sel_out stays 0; wrap_out pulses on every BLANK -> SCAN transition.
REQ-021 stop_in=1 in SCAN or BLANK: next state IDLE; en_out=0, sel_out=0, busy_out=0, and no wrap_out pulse, even if a wrap transition would otherwise occur that cycle.
REQ-022 start_in and stop_in high together in IDLE: stop wins; the block remains in IDLE.
REQ-023 start_in outside IDLE is ignored; dwell_in and last_in changes during a scan are ignored until the next start.
REQ-024 Latency: en_out rises on the first clock edge after start_in is sampled high.

Reset
REQ-025 On rst_n_in=0, immediately and independent of clk_in: state=IDLE, sel_out=0, en_out=0, busy_out=0, wrap_out=0, dwell_r=0, last_r=0, dwell counter=0.
REQ-026 Reset asserted mid-scan aborts the scan with the values of REQ-025; after release the block waits in IDLE for start_in.

Structure
REQ-027 A shared package holds the state encoding (IDLE=0, SCAN=1, BLANK=2) and the SEL_W and DW_W defaults.
REQ-028 A single sub-module, scan_dwell_cnt, contains the loadable down-counter and asserts an expire flag; all other logic lives in decoder_scan_seq.
REQ-029 The top-level bench instantiates decoder_scan_seq driving decoder_al_4_16_bh and checks that exactly one y_out bit is low whenever en_out=1.

Verification
REQ-030 Reset check: rst_n_in=0 mid-scan at sel_out=5 -> all outputs are 0 within the same time step, with no clock edge required.
REQ-031 Basic scan: dwell_in=3, last_in=3, pulse start_in -> sel_out sequence 0,1,2,3,0; each code held 3 cycles with en_out=1, separated by 1 en_out=0 cycle; wrap_out pulses once per 16-cycle loop.
REQ-032 Zero dwell: dwell_in=0, last_in=1 -> each code is enabled for 1 cycle; en_out pattern is 1,0,1,0,...
REQ-033 Full range: dwell_in=1, last_in=15 -> sel_out counts 0..15 then 0, and wrap_out goes high exactly once per 32 cycles.
REQ-034 Stop precedence: stop_in=1 in the BLANK cycle after sel_out=3 with last_in=3 -> state IDLE, sel_out=0, en_out=0, and no wrap_out pulse.
REQ-035 Simultaneous start_in=1 and stop_in=1 in IDLE -> busy_out stays 0; changing last_in mid-scan from 3 to 7 has no effect until the next start.
